// File: rtl/osc_fab_reset_seq.sv
// Fabric reset sequencer for the RC-oscillator fabric clock domain.
// Holds the fabric in reset until CCC lock has been stable and the MSS is
// ready, then waits a settling delay. It also handles lock-loss recovery,
// software-requested reset pulses and lock-loss status reporting.
module osc_fab_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_DELAY      = 256,
  parameter int SW_RST_CYCLES      = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CCC_LOCK,
  input  logic       MSS_READY,
  input  logic       SW_RESET_REQ,
  output logic       FAB_RESET_N,
  output logic       LOCK_LOST,
  output logic [7:0] LOCK_LOST_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_RESET       = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_WAIT_MSS    = 3'd3,
    S_RELEASE     = 3'd4,
    S_RUN         = 3'd5,
    S_SW_RESET    = 3'd6
  } state_t;

  // Terminal counts: each timed state leaves when cnt reaches N-1.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] REL_LAST  = 16'(RELEASE_DELAY - 1);
  localparam logic [15:0] SW_LAST   = 16'(SW_RST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   lock_s;
  logic                   rdy_s;
  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            cnt;
  logic [15:0]            cnt_nxt;
  logic                   lost_evt;

  // Synchronise the two oscillator-asynchronous status inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_sync <= '0;
      rdy_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], CCC_LOCK};
      rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], MSS_READY};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign rdy_s  = rdy_sync[SYNC_STAGES-1];

  // Next state and counter. cnt defaults to 0 so it clears on every
  // transition and only advances while dwelling in a timed state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    lost_evt  = 1'b0;
    case (state)
      S_RESET:     state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_nxt = S_LOCK_STABLE;
      S_LOCK_STABLE: begin
        if (!lock_s)                state_nxt = S_WAIT_LOCK;
        else if (cnt == LOCK_LAST)  state_nxt = S_WAIT_MSS;
        else                        cnt_nxt   = cnt + 16'd1;
      end
      S_WAIT_MSS: begin
        if (!lock_s)     state_nxt = S_WAIT_LOCK;
        else if (rdy_s)  state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!lock_s)               state_nxt = S_WAIT_LOCK;
        else if (cnt == REL_LAST)  state_nxt = S_RUN;
        else                       cnt_nxt   = cnt + 16'd1;
      end
      S_RUN: begin
        // Lock loss outranks a same-cycle software request.
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          lost_evt  = 1'b1;
        end else if (SW_RESET_REQ) begin
          state_nxt = S_SW_RESET;
        end
      end
      S_SW_RESET: begin
        // Returns straight to RUN: lock is still monitored, MSS is not.
        if (!lock_s)              state_nxt = S_WAIT_LOCK;
        else if (cnt == SW_LAST)  state_nxt = S_RUN;
        else                      cnt_nxt   = cnt + 16'd1;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // State, counter, registered fabric reset and lock-loss status.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= S_RESET;
      cnt           <= '0;
      FAB_RESET_N   <= 1'b0;
      LOCK_LOST     <= 1'b0;
      LOCK_LOST_CNT <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      FAB_RESET_N <= (state_nxt == S_RUN);
      if (lost_evt) begin
        LOCK_LOST <= 1'b1;
        if (LOCK_LOST_CNT != 8'hFF) LOCK_LOST_CNT <= LOCK_LOST_CNT + 8'd1;
      end
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_osc_fab_reset_seq.sv
// Bench for osc_fab_reset_seq: directed scenarios plus a random soak, every
// cycle checked against a dwell-time reference model.
module tb_osc_fab_reset_seq;

  localparam int SS = 2;
  localparam int LC = 8;
  localparam int RD = 4;
  localparam int SW = 16;

  // Observable phase codes as published on STATE.
  localparam int P_RESET = 0, P_WLOCK = 1, P_QUAL = 2, P_WMSS = 3,
                 P_REL = 4, P_RUN = 5, P_SW = 6;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CCC_LOCK = 1'b1;
  logic       MSS_READY = 1'b1;
  logic       SW_RESET_REQ = 1'b0;
  logic       FAB_RESET_N;
  logic       LOCK_LOST;
  logic [7:0] LOCK_LOST_CNT;
  logic [2:0] STATE;

  int n_tests = 0;
  int n_fail  = 0;

  osc_fab_reset_seq #(
    .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LC),
    .RELEASE_DELAY(RD), .SW_RST_CYCLES(SW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CCC_LOCK(CCC_LOCK), .MSS_READY(MSS_READY),
    .SW_RESET_REQ(SW_RESET_REQ), .FAB_RESET_N(FAB_RESET_N), .LOCK_LOST(LOCK_LOST),
    .LOCK_LOST_CNT(LOCK_LOST_CNT), .STATE(STATE)
  );

  always #10 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: synchronisers are plain delay lines, and each timed phase
  // is described by how many edges it lasts since it was entered.
  bit lp [SS];
  bit rp [SS];
  int m_phase, m_edge, m_entry, m_lcnt;
  bit m_fab, m_lost;

  task automatic model_reset();
    for (int i = 0; i < SS; i++) begin lp[i] = 0; rp[i] = 0; end
    m_phase = P_RESET; m_edge = 0; m_entry = 0;
    m_fab = 0; m_lost = 0; m_lcnt = 0;
  endtask

  task automatic model_edge();
    bit ls, rs;
    int nx, dwell;
    ls = lp[SS-1];
    rs = rp[SS-1];
    for (int i = SS-1; i > 0; i--) begin lp[i] = lp[i-1]; rp[i] = rp[i-1]; end
    lp[0] = CCC_LOCK;
    rp[0] = MSS_READY;
    m_edge++;
    dwell = m_edge - m_entry;
    nx = m_phase;
    if (m_phase == P_RESET)         nx = P_WLOCK;
    else if (m_phase == P_WLOCK)    nx = ls ? P_QUAL : P_WLOCK;
    else if (!ls) begin
      if (m_phase == P_RUN) begin
        m_lost = 1;
        m_lcnt = (m_lcnt < 255) ? m_lcnt + 1 : 255;
      end
      nx = P_WLOCK;
    end
    else if (m_phase == P_QUAL && dwell == LC) nx = P_WMSS;
    else if (m_phase == P_WMSS && rs)          nx = P_REL;
    else if (m_phase == P_REL  && dwell == RD) nx = P_RUN;
    else if (m_phase == P_RUN  && SW_RESET_REQ) nx = P_SW;
    else if (m_phase == P_SW   && dwell == SW) nx = P_RUN;
    if (nx != m_phase) m_entry = m_edge;
    m_phase = nx;
    m_fab = (nx == P_RUN);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance DUT and model together, compare on the falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("state", {13'd0, STATE}, 16'(m_phase));
    chk("fab_reset_n", {15'd0, FAB_RESET_N}, {15'd0, m_fab});
    chk("lock_lost", {15'd0, LOCK_LOST}, {15'd0, m_lost});
    chk("lock_lost_cnt", {8'd0, LOCK_LOST_CNT}, 16'(m_lcnt));
  endtask

  task automatic wait_phase(input int ph, input int budget);
    bit ok;
    for (int i = 0; i < budget && m_phase != ph; i++) step();
    ok = (m_phase == ph);
    chk("reach_phase", {15'd0, ok}, 16'd1);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic do_reset();
    @(negedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("rst_state", {13'd0, STATE}, 16'd0);
    chk("rst_fab", {15'd0, FAB_RESET_N}, 16'd0);
    chk("rst_lost", {15'd0, LOCK_LOST}, 16'd0);
    chk("rst_lost_cnt", {8'd0, LOCK_LOST_CNT}, 16'd0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Edge number (from reset release) at which FAB_RESET_N first reads high.
  task automatic rise_edge(input int start, input int budget, output int edge_no);
    edge_no = 0;
    for (int e = start; e <= budget && edge_no == 0; e++) begin
      step();
      if (FAB_RESET_N === 1'b1) edge_no = e;
    end
  endtask

  initial begin
    int rise, n, low;
    int walk[$];
    bit seen;
    model_reset();

    // Clean power-up: release at edge 2+1+8+1+4 = 16, phases walk 0..5.
    do_reset();
    walk.push_back(int'(STATE));
    rise = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (int'(STATE) != walk[$]) walk.push_back(int'(STATE));
      if (rise == 0 && FAB_RESET_N === 1'b1) rise = e;
    end
    chk("release_edge", 16'(rise), 16'd16);
    chk("walk_len", 16'(walk.size()), 16'd6);
    for (int i = 0; i < walk.size() && i < 6; i++) chk("walk", 16'(walk[i]), 16'(i));

    // One-cycle lock glitch while qualifying (cnt=5 after edge 8): lock_s low
    // at edge 10, WAIT_LOCK at 11, requalify from 12 -> release at 25.
    do_reset();
    for (int e = 1; e <= 8; e++) step();
    CCC_LOCK = 1'b0;
    step();
    CCC_LOCK = 1'b1;
    rise_edge(10, 40, rise);
    chk("glitch_release_edge", 16'(rise), 16'd25);
    chk("glitch_no_lost", {15'd0, LOCK_LOST}, 16'd0);

    // MSS not ready: fabric held; release RD+SS+1 edges after it rises.
    MSS_READY = 1'b0;
    do_reset();
    wait_phase(P_WMSS, 40);
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); seen |= FAB_RESET_N; end
    chk("mss_hold", {15'd0, seen}, 16'd0);
    MSS_READY = 1'b1;
    rise_edge(1, 30, n);
    chk("mss_release", 16'(n), 16'(RD + SS + 1));

    // Software reset: exactly SW low cycles; a repeat request is ignored.
    chk("pre_sw_lost", {15'd0, LOCK_LOST}, 16'd0);
    SW_RESET_REQ = 1'b1;
    step();
    SW_RESET_REQ = 1'b0;
    low = 0;
    for (int i = 0; i < 40 && FAB_RESET_N === 1'b0; i++) begin
      low++;
      if (low == 5) SW_RESET_REQ = 1'b1;
      step();
      SW_RESET_REQ = 1'b0;
    end
    chk("sw_low_cycles", 16'(low), 16'(SW));

    // Request coincident with lock loss seen in RUN: lock loss wins.
    CCC_LOCK = 1'b0;
    step();
    step();
    SW_RESET_REQ = 1'b1;
    step();
    SW_RESET_REQ = 1'b0;
    chk("coinc_state", {13'd0, STATE}, 16'(P_WLOCK));
    chk("coinc_fab", {15'd0, FAB_RESET_N}, 16'd0);
    chk("coinc_lost", {15'd0, LOCK_LOST}, 16'd1);
    chk("coinc_cnt", {8'd0, LOCK_LOST_CNT}, 16'd1);

    // Lock loss in RUN: falls SS edges after the first edge that samples it.
    CCC_LOCK = 1'b1;
    wait_phase(P_RUN, 60);
    CCC_LOCK = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && FAB_RESET_N === 1'b1; i++) begin step(); n++; end
    chk("loss_latency", 16'(n - 1), 16'(SS));
    chk("loss_cnt", {8'd0, LOCK_LOST_CNT}, 16'd2);
    for (int r = 0; r < 298; r++) begin
      CCC_LOCK = 1'b1;
      wait_phase(P_RUN, 60);
      CCC_LOCK = 1'b0;
      wait_phase(P_WLOCK, 10);
    end
    chk("loss_saturate", {8'd0, LOCK_LOST_CNT}, 16'd255);

    // Asynchronous reset in the middle of RELEASE, then full replay.
    CCC_LOCK = 1'b1;
    wait_phase(P_REL, 60);
    step();
    do_reset();
    rise_edge(1, 20, rise);
    chk("replay_release_edge", 16'(rise), 16'd16);

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) CCC_LOCK = ~CCC_LOCK;
      if ($urandom_range(0, 19) == 0) MSS_READY = ~MSS_READY;
      SW_RESET_REQ = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
